// File: rtl/riscv_ctrl_pkg.sv
// Shared encodings for the multi-cycle RISC-V control path: opcodes, FSM states,
// datapath select codes and the control word. Optional LUI support: MAIN_FSM_LUI_EN.
package riscv_ctrl_pkg;

    localparam logic [6:0] OP_LW  = 7'b0000011;
    localparam logic [6:0] OP_SW  = 7'b0100011;
    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_JAL = 7'b1101111;
    localparam logic [6:0] OP_BEQ = 7'b1100011;
    localparam logic [6:0] OP_LUI = 7'b0110111;

    typedef enum logic [3:0] {
        FETCH    = 4'd0,
        DECODE   = 4'd1,
        MEMADR   = 4'd2,
        MEMREAD  = 4'd3,
        MEMWB    = 4'd4,
        MEMWRITE = 4'd5,
        EXECR    = 4'd6,
        ALUWB    = 4'd7,
        EXECI    = 4'd8,
        JAL      = 4'd9,
        BEQ      = 4'd10,
        LUI      = 4'd11
    } state_t;

    localparam logic [1:0] RES_ALUOUT    = 2'b00;
    localparam logic [1:0] RES_DATA      = 2'b01;
    localparam logic [1:0] RES_ALURESULT = 2'b10;

    localparam logic [1:0] SRCA_PC    = 2'b00;
    localparam logic [1:0] SRCA_OLDPC = 2'b01;
    localparam logic [1:0] SRCA_RS1   = 2'b10;
    localparam logic [1:0] SRCA_ZERO  = 2'b11;

    localparam logic [1:0] SRCB_RS2  = 2'b00;
    localparam logic [1:0] SRCB_IMM  = 2'b01;
    localparam logic [1:0] SRCB_FOUR = 2'b10;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    typedef struct packed {
        logic       pc_update;
        logic       branch;
        logic       ir_write;
        logic       reg_write;
        logic       mem_write;
        logic       adr_src;
        logic [1:0] result_src;
        logic [1:0] alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
    } ctrl_t;

    // True when DECODE has somewhere to send this opcode.
    function automatic logic op_supported(input logic [6:0] op);
        logic ok;
        case (op)
            OP_LW, OP_SW, OP_R, OP_I, OP_JAL, OP_BEQ: ok = 1'b1;
`ifdef MAIN_FSM_LUI_EN
            OP_LUI:                                   ok = 1'b1;
`endif
            default:                                  ok = 1'b0;
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/main_fsm_outputs.sv
// Combinational state-to-control-word map; only the FETCH enables look at mem_ready.
// The LUI row exists only when MAIN_FSM_LUI_EN is defined.
module main_fsm_outputs
    import riscv_ctrl_pkg::*;
(
    input  state_t state_i,
    input  logic   mem_ready_i,
    output ctrl_t  ctrl_o
);

    // Control word per state; every field not set below stays zero.
    always_comb begin
        ctrl_o = '0;
        case (state_i)
            FETCH: begin
                ctrl_o.alu_src_a  = SRCA_PC;
                ctrl_o.alu_src_b  = SRCB_FOUR;
                ctrl_o.alu_op     = ALUOP_ADD;
                ctrl_o.result_src = RES_ALURESULT;
                ctrl_o.ir_write   = mem_ready_i;
                ctrl_o.pc_update  = mem_ready_i;
            end
            DECODE: begin
                ctrl_o.alu_src_a = SRCA_OLDPC;
                ctrl_o.alu_src_b = SRCB_IMM;
                ctrl_o.alu_op    = ALUOP_ADD;
            end
            MEMADR: begin
                ctrl_o.alu_src_a = SRCA_RS1;
                ctrl_o.alu_src_b = SRCB_IMM;
                ctrl_o.alu_op    = ALUOP_ADD;
            end
            MEMREAD: begin
                ctrl_o.adr_src    = 1'b1;
                ctrl_o.result_src = RES_ALUOUT;
            end
            MEMWB: begin
                ctrl_o.result_src = RES_DATA;
                ctrl_o.reg_write  = 1'b1;
            end
            MEMWRITE: begin
                ctrl_o.adr_src    = 1'b1;
                ctrl_o.result_src = RES_ALUOUT;
                ctrl_o.mem_write  = 1'b1;
            end
            EXECR: begin
                ctrl_o.alu_src_a = SRCA_RS1;
                ctrl_o.alu_src_b = SRCB_RS2;
                ctrl_o.alu_op    = ALUOP_FUNCT;
            end
            EXECI: begin
                ctrl_o.alu_src_a = SRCA_RS1;
                ctrl_o.alu_src_b = SRCB_IMM;
                ctrl_o.alu_op    = ALUOP_FUNCT;
            end
            JAL: begin
                ctrl_o.alu_src_a  = SRCA_OLDPC;
                ctrl_o.alu_src_b  = SRCB_FOUR;
                ctrl_o.alu_op     = ALUOP_ADD;
                ctrl_o.result_src = RES_ALUOUT;
                ctrl_o.pc_update  = 1'b1;
            end
            BEQ: begin
                ctrl_o.alu_src_a  = SRCA_RS1;
                ctrl_o.alu_src_b  = SRCB_RS2;
                ctrl_o.alu_op     = ALUOP_SUB;
                ctrl_o.result_src = RES_ALUOUT;
                ctrl_o.branch     = 1'b1;
            end
`ifdef MAIN_FSM_LUI_EN
            LUI: begin
                ctrl_o.alu_src_a = SRCA_ZERO;
                ctrl_o.alu_src_b = SRCB_IMM;
                ctrl_o.alu_op    = ALUOP_ADD;
            end
`endif
            ALUWB: begin
                ctrl_o.result_src = RES_ALUOUT;
                ctrl_o.reg_write  = 1'b1;
            end
            default: ctrl_o = '0;
        endcase
    end

endmodule

// File: rtl/main_fsm.sv
// Main control FSM of the multi-cycle RISC-V core: state register, next-state logic
// and reset gating of the control word. Optional LUI support: MAIN_FSM_LUI_EN.
module main_fsm
    import riscv_ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic [6:0] op,
    input  logic       mem_ready,
    output logic       PCUpdate,
    output logic       Branch,
    output logic       IRWrite,
    output logic       RegWrite,
    output logic       MemWrite,
    output logic       AdrSrc,
    output logic [1:0] ResultSrc,
    output logic [1:0] ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] ALUOp,
    output logic       illegal_op,
    output logic [3:0] state
);

    state_t state_q;
    ctrl_t  ctrl_s;
    ctrl_t  ctrl_gated_s;

    // State register and next-state sequencing; stray encodings fall back to FETCH.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= FETCH;
        end else begin
            case (state_q)
                FETCH:    state_q <= mem_ready ? DECODE : FETCH;
                DECODE: begin
                    case (op)
                        OP_LW, OP_SW: state_q <= MEMADR;
                        OP_R:         state_q <= EXECR;
                        OP_I:         state_q <= EXECI;
                        OP_JAL:       state_q <= JAL;
                        OP_BEQ:       state_q <= BEQ;
`ifdef MAIN_FSM_LUI_EN
                        OP_LUI:       state_q <= LUI;
`endif
                        default:      state_q <= FETCH;
                    endcase
                end
                MEMADR: begin
                    case (op)
                        OP_LW:   state_q <= MEMREAD;
                        OP_SW:   state_q <= MEMWRITE;
                        default: state_q <= FETCH;
                    endcase
                end
                MEMREAD:  state_q <= mem_ready ? MEMWB : MEMREAD;
                MEMWB:    state_q <= FETCH;
                MEMWRITE: state_q <= mem_ready ? FETCH : MEMWRITE;
                EXECR:    state_q <= ALUWB;
                EXECI:    state_q <= ALUWB;
                JAL:      state_q <= ALUWB;
                BEQ:      state_q <= FETCH;
`ifdef MAIN_FSM_LUI_EN
                LUI:      state_q <= ALUWB;
`endif
                ALUWB:    state_q <= FETCH;
                default:  state_q <= FETCH;
            endcase
        end
    end

    main_fsm_outputs u_outputs (
        .state_i     (state_q),
        .mem_ready_i (mem_ready),
        .ctrl_o      (ctrl_s)
    );

    // A low rst_n blanks the whole control word so nothing is written in the reset cycle.
    always_comb begin
        if (rst_n) begin
            ctrl_gated_s = ctrl_s;
        end else begin
            ctrl_gated_s = '0;
        end
    end

    assign PCUpdate   = ctrl_gated_s.pc_update;
    assign Branch     = ctrl_gated_s.branch;
    assign IRWrite    = ctrl_gated_s.ir_write;
    assign RegWrite   = ctrl_gated_s.reg_write;
    assign MemWrite   = ctrl_gated_s.mem_write;
    assign AdrSrc     = ctrl_gated_s.adr_src;
    assign ResultSrc  = ctrl_gated_s.result_src;
    assign ALUSrcA    = ctrl_gated_s.alu_src_a;
    assign ALUSrcB    = ctrl_gated_s.alu_src_b;
    assign ALUOp      = ctrl_gated_s.alu_op;
    assign illegal_op = rst_n & (state_q == DECODE) & ~op_supported(op);
    assign state      = state_q;

endmodule

// File: doc/main_fsm.md
# main_fsm

Main control state machine of the multi-cycle RISC-V core. Consumes the 7-bit opcode of the latched instruction, the same field the immediate-select decoder reads. Sequences each instruction through fetch, decode, execute, memory and writeback cycles, and drives every datapath enable and mux select except ImmSrc and ALUControl. Supports a memory ready handshake so fetch and data accesses can stall.

## Interface
Parameters:
- none (encodings are fixed in the shared package)

Ports:
- clk  in  1  core clock; all state updates on the rising edge
- rst_n  in  1  synchronous reset, active low
- op  in  7  opcode field of the instruction register
- mem_ready  in  1  memory has completed the current access this cycle
- PCUpdate  out  1  PC register write enable
- Branch  out  1  conditional PC write; datapath ANDs it with Zero
- IRWrite  out  1  instruction register and OldPC write enable
- RegWrite  out  1  register file write enable
- MemWrite  out  1  data memory write request
- AdrSrc  out  1  memory address select: 0 = PC, 1 = ALUOut
- ResultSrc  out  2  00 = ALUOut, 01 = Data, 10 = ALUResult
- ALUSrcA  out  2  00 = PC, 01 = OldPC, 10 = rs1 reg A, 11 = zero
- ALUSrcB  out  2  00 = rs2 reg B, 01 = ImmExt, 10 = constant 4
- ALUOp  out  2  00 = add, 01 = sub, 10 = use funct fields
- illegal_op  out  1  one-cycle pulse when an unsupported opcode is decoded
- state  out  4  current state, for debug

## Operation
States, their asserted outputs, and next state. Unlisted outputs are 0.
- FETCH: AdrSrc 0, ALUSrcA 00, ALUSrcB 10, ALUOp 00, ResultSrc 10.
  - IRWrite and PCUpdate are asserted only when mem_ready = 1.
  - Stays in FETCH while mem_ready = 0; goes to DECODE when mem_ready = 1.
- DECODE: ALUSrcA 01, ALUSrcB 01, ALUOp 00 (computes the branch/jump target). Next state by op:
  - 0000011 (lw) or 0100011 (sw) → MEMADR
  - 0110011 → EXECR
  - 0010011 → EXECI
  - 1101111 → JAL
  - 1100011 → BEQ
  - 0110111 → LUI (only when the macro is defined)
  - any other op → FETCH, with illegal_op = 1 for this cycle
- MEMADR: ALUSrcA 10, ALUSrcB 01, ALUOp 00. Goes to MEMREAD for lw, MEMWRITE for sw.
- MEMREAD: AdrSrc 1, ResultSrc 00. Waits while mem_ready = 0, then goes to MEMWB.
- MEMWB: ResultSrc 01, RegWrite 1 → FETCH.
- MEMWRITE: AdrSrc 1, ResultSrc 00, MemWrite 1. MemWrite is held asserted while waiting. Goes to FETCH on mem_ready = 1.
- EXECR: ALUSrcA 10, ALUSrcB 00, ALUOp 10 → ALUWB.
- EXECI: ALUSrcA 10, ALUSrcB 01, ALUOp 10 → ALUWB.
- JAL: ALUSrcA 01, ALUSrcB 10, ALUOp 00, ResultSrc 00, PCUpdate 1 → ALUWB.
- BEQ: ALUSrcA 10, ALUSrcB 00, ALUOp 01, ResultSrc 00, Branch 1 → FETCH.
- LUI: ALUSrcA 11, ALUSrcB 01, ALUOp 00 → ALUWB.
- ALUWB: ResultSrc 00, RegWrite 1 → FETCH.

Illegal or unreachable state encodings return to FETCH on the next edge.

## Timing
- Outputs are combinational from state. Only the FETCH enables (IRWrite, PCUpdate) are Mealy-gated by mem_ready.
- Reset: while rst_n = 0 at a clock edge, state becomes FETCH (0).
- During any cycle with rst_n = 0, all enables (PCUpdate, Branch, IRWrite, RegWrite, MemWrite, illegal_op) are forced to 0 and all selects to 00.
- A reset mid-instruction abandons that instruction; no write completes in the reset cycle.
- Cycles per instruction with mem_ready held at 1:
  - lw: 5
  - sw: 4
  - R-type, I-type, jal, lui: 4
  - beq: 3
  - illegal opcode: 2
- Each cycle of mem_ready = 0 in FETCH, MEMREAD or MEMWRITE adds exactly one cycle.
- op is sampled only in DECODE and MEMADR. It must be stable there; IRWrite is 0 in both states.

## Configuration
- MAIN_FSM_LUI_EN defined: the LUI state exists and op 0110111 is executed as rd = 0 + ImmExt.
- MAIN_FSM_LUI_EN undefined: 0110111 is treated as illegal (illegal_op pulse, return to FETCH), and ALUSrcA 11 is never driven.

## Structure
- Shared package riscv_ctrl_pkg holds:
  - opcode constants (OP_LW, OP_SW, OP_R, OP_I, OP_JAL, OP_BEQ, OP_LUI)
  - the 4-bit state enum (FETCH = 0 through LUI = 11)
  - the ResultSrc, ALUSrcA, ALUSrcB and ALUOp encodings
- One sub-module is natural: main_fsm_outputs, a purely combinational mapping from state (and mem_ready) to the control word. The state register and next-state logic stay in main_fsm.

## Test plan
- Reset: rst_n = 0 for 2 cycles with op = 0110011 → state 0 and all enables 0; on release, FETCH asserts IRWrite = 1, PCUpdate = 1.
- lw, op = 0000011, mem_ready = 1 → state sequence 0,1,2,3,4,0; RegWrite = 1 only in state 4 with ResultSrc 01.
- sw with mem_ready low for 3 cycles in MEMWRITE → MemWrite held 1 for 4 cycles, then FETCH; RegWrite never asserted.
- beq, op = 1100011 → states 0,1,10,0; Branch = 1 and ALUOp = 01 only in state 10.
- Unsupported op 1110011, and lui 0110111 with the macro undefined → DECODE pulses illegal_op = 1 and returns to FETCH. With the macro defined, lui gives states 0,1,11,7 with ALUSrcA = 11.
- Fetch stall: mem_ready = 0 for 5 cycles in FETCH, then rst_n = 0 mid-jal → IRWrite stays 0 until ready; the reset returns to FETCH with no RegWrite.
